exc_arbiter: RTL and testbench

- Exception/interrupt front end that sits directly upstream of the CP0 block.
- Collects synchronous exception flags from decode/execute, plus edge-triggered external interrupt lines that pass through a mask register.
- Prioritises them at instruction boundaries and issues one registered request (exp_valid + exp_src) to CP0, which maps onto CP0's enable/ExpSrc.
- Tracks handler residency until CP0 reports eret, so only one exception is in flight at a time.

---
 rtl/exc_arbiter.sv | 75 +++++++
 tb/tb_exc_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/exc_arbiter.sv
// exc_arbiter: prioritises sync exceptions and masked edge interrupts into one registered CP0 request
module exc_arbiter #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid,
  input  logic               stall,
  input  logic               is_syscall,
  input  logic               is_illegal,
  input  logic               is_ovf,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic               is_eret,
  input  logic               exp_block,
  output logic               exp_valid,
  output logic [2:0]         exp_src,
  output logic               flush,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic               double_fault
);
  typedef enum logic [1:0] {IDLE, ISSUE, HANDLER} state_t;
  state_t state, state_nx;
  logic [NUM_IRQ-1:0] irq_q, req, gnt, clr;
  logic [2:0] win;
  logic sync_exc, take;
  always_comb begin
    req = pending & irq_mask;
    gnt = '0;
    win = 3'b000;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        win = 3'(4 + k);
      end
    sync_exc = is_illegal | is_syscall | is_ovf;
    win = is_illegal ? 3'b010 : is_syscall ? 3'b001 : is_ovf ? 3'b011 : win;
    take = (state == IDLE) & inst_valid & ~stall & (sync_exc | (|req));
    clr = (take & ~sync_exc) ? gnt : '0;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? ISSUE : IDLE;
      ISSUE:   state_nx = exp_block ? ISSUE : HANDLER;
      HANDLER: state_nx = is_eret ? IDLE : HANDLER;
      default: state_nx = IDLE;
    endcase
  end
  assign exp_valid  = state == ISSUE;
  assign in_handler = state == HANDLER;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      exp_src      <= 3'b000;
      flush        <= 1'b0;
      irq_q        <= '0;
      pending      <= '0;
      irq_mask     <= '0;
      double_fault <= 1'b0;
    end else begin
      state        <= state_nx;
      irq_q        <= irq;
      pending      <= (pending & ~clr) | (irq & ~irq_q);
      irq_mask     <= mask_we ? mask_din : irq_mask;
      exp_src      <= take ? win : (state == ISSUE && !exp_block) ? 3'b000 : exp_src;
      flush        <= (state == ISSUE) & ~exp_block;
      double_fault <= double_fault | ((state == HANDLER) & inst_valid & sync_exc);
    end
  end
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: table-driven directed vectors plus hand sequences for exc_arbiter
module tb_exc_arbiter;
  logic clk = 1'b0;
  logic rst, inst_valid, stall, is_syscall, is_illegal, is_ovf, mask_we, is_eret, exp_block;
  logic [3:0] irq, mask_din, pending, irq_mask;
  logic exp_valid, flush, in_handler, double_fault;
  logic [2:0] exp_src;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  exc_arbiter #(.NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .stall(stall),
    .is_syscall(is_syscall), .is_illegal(is_illegal), .is_ovf(is_ovf),
    .irq(irq), .mask_we(mask_we), .mask_din(mask_din), .is_eret(is_eret),
    .exp_block(exp_block), .exp_valid(exp_valid), .exp_src(exp_src),
    .flush(flush), .in_handler(in_handler), .pending(pending),
    .irq_mask(irq_mask), .double_fault(double_fault)
  );

  typedef struct packed {
    logic rst, iv, st, sys, ill, ovf;
    logic [3:0] irq;
    logic mwe;
    logic [3:0] mdin;
    logic eret, blk;
    logic ev;
    logic [2:0] src;
    logic fl, inh;
    logic [3:0] pend, mask;
    logic df;
  } vec_t;
  vec_t tbl[$];

  task automatic drive(input vec_t v);
    rst = v.rst; inst_valid = v.iv; stall = v.st; is_syscall = v.sys;
    is_illegal = v.ill; is_ovf = v.ovf; irq = v.irq; mask_we = v.mwe;
    mask_din = v.mdin; is_eret = v.eret; exp_block = v.blk;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [14:0] got, exp;
    got = {exp_valid, exp_src, flush, in_handler, pending, irq_mask, double_fault};
    exp = {v.ev, v.src, v.fl, v.inh, v.pend, v.mask, v.df};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got ev=%b src=%b fl=%b inh=%b pend=%b mask=%b df=%b want ev=%b src=%b fl=%b inh=%b pend=%b mask=%b df=%b",
               name, got[14], got[13:11], got[10], got[9], got[8:5], got[4:1], got[0],
               v.ev, v.src, v.fl, v.inh, v.pend, v.mask, v.df);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    vec_t z;
    z = '0;
    drive(z);
    rst = 1'b1;
    // rst iv st sys ill ovf irq mwe mdin eret blk | ev src fl inh pend mask df
    tbl.push_back('{1,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,1,0,1,0,0,4'b0000,0,4'b0000,0,0, 1,3'd1,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,0,1,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    // priority: all three flags, then syscall+ovf
    tbl.push_back('{0,1,0,1,1,1,4'b0000,0,4'b0000,0,0, 1,3'd2,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,1,0,1,0,1,4'b0000,0,4'b0000,0,0, 1,3'd1,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    // stall defers, then overflow issues
    tbl.push_back('{0,1,1,0,0,1,4'b0000,0,4'b0000,0,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,1,0,0,0,1,4'b0000,0,4'b0000,0,0, 1,3'd3,0,0,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0000,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0000,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    // masked irq2 latches, mask write, issue two cycles later
    tbl.push_back('{0,1,0,0,0,0,4'b0100,0,4'b0000,0,0, 0,3'd0,0,0,4'b0100,4'b0000,0});
    tbl.push_back('{0,1,0,0,0,0,4'b0100,1,4'b0100,0,0, 0,3'd0,0,0,4'b0100,4'b0100,0});
    tbl.push_back('{0,1,0,0,0,0,4'b0100,0,4'b0000,0,0, 1,3'd6,0,0,4'b0000,4'b0100,0});
    // backpressure
    tbl.push_back('{0,0,0,0,0,0,4'b0100,0,4'b0000,0,1, 1,3'd6,0,0,4'b0000,4'b0100,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0100,0,4'b0000,0,1, 1,3'd6,0,0,4'b0000,4'b0100,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0100,0,4'b0000,0,1, 1,3'd6,0,0,4'b0000,4'b0100,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0100,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0100,0});
    // nested irq0 and double fault inside handler
    tbl.push_back('{0,0,0,0,0,0,4'b0000,1,4'b0001,0,0, 0,3'd0,0,1,4'b0000,4'b0001,0});
    tbl.push_back('{0,0,0,0,0,0,4'b0001,0,4'b0000,0,0, 0,3'd0,0,1,4'b0001,4'b0001,0});
    tbl.push_back('{0,1,0,1,0,0,4'b0001,0,4'b0000,0,0, 0,3'd0,0,1,4'b0001,4'b0001,1});
    tbl.push_back('{0,0,0,0,0,0,4'b0001,0,4'b0000,1,0, 0,3'd0,0,0,4'b0001,4'b0001,1});
    tbl.push_back('{0,1,0,0,0,0,4'b0001,0,4'b0000,0,0, 1,3'd4,0,0,4'b0000,4'b0001,1});
    tbl.push_back('{0,0,0,0,0,0,4'b0001,0,4'b0000,0,0, 0,3'd0,1,1,4'b0000,4'b0001,1});
    tbl.push_back('{0,0,0,0,0,0,4'b0001,0,4'b0000,1,0, 0,3'd0,0,0,4'b0000,4'b0001,1});
    // reset during a blocked ISSUE
    tbl.push_back('{0,1,0,0,1,0,4'b0001,0,4'b0000,0,0, 1,3'd2,0,0,4'b0000,4'b0001,1});
    tbl.push_back('{0,0,0,0,0,0,4'b1111,0,4'b0000,0,1, 1,3'd2,0,0,4'b1110,4'b0001,1});
    tbl.push_back('{1,0,0,0,0,0,4'b1111,0,4'b0000,0,1, 0,3'd0,0,0,4'b0000,4'b0000,0});
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // edge history is cleared by reset, so a held line registers as a fresh edge
    step("post_rst_edge", '{0,0,0,0,0,0,4'b1111,0,4'b0000,0,0, 0,3'd0,0,0,4'b1111,4'b0000,0});
    step("rst_again",     '{1,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,0,0,4'b0000,4'b0000,0});
    // set beats clear when irq0 re-rises on the edge it is issued
    step("sw_mask",   '{0,0,0,0,0,0,4'b0000,1,4'b0001,0,0, 0,3'd0,0,0,4'b0000,4'b0001,0});
    step("sw_rise1",  '{0,0,0,0,0,0,4'b0001,0,4'b0000,0,0, 0,3'd0,0,0,4'b0001,4'b0001,0});
    step("sw_fall",   '{0,0,0,0,0,0,4'b0000,0,4'b0000,0,0, 0,3'd0,0,0,4'b0001,4'b0001,0});
    step("sw_setwin", '{0,1,0,0,0,0,4'b0001,0,4'b0000,0,0, 1,3'd4,0,0,4'b0001,4'b0001,0});
    step("sw_hold",   '{0,0,0,0,0,0,4'b0001,0,4'b0000,0,0, 0,3'd0,1,1,4'b0001,4'b0001,0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
